// File: rtl/i2s_shot_tone_tx.sv
// I2S DAC transmitter that plays short decaying square-wave shot/hit effects.
// Optional macro SHOT_NOISE_EN replaces the fire tone with Galois LFSR noise.
module i2s_shot_tone_tx #(
    parameter int          BCLK_DIV   = 16,
    parameter int          FIRE_HALF  = 20,
    parameter int          HIT_HALF   = 8,
    parameter int          DUR_FRAMES = 4096,
    parameter logic [15:0] AMP_INIT   = 16'h3FFF
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic hit,
    output logic aud_bclk,
    output logic aud_daclrck,
    output logic aud_dacdat,
    output logic busy
);
    localparam int DW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int FW   = $clog2(DUR_FRAMES);
    localparam int HMAX = (FIRE_HALF > HIT_HALF) ? FIRE_HALF : HIT_HALF;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    typedef enum logic {IDLE, PLAY} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_FIRE, REQ_HIT} req_t;

    logic [DW-1:0] div_cnt;
    logic          bclk_q;
    logic [5:0]    bit_cnt;
    state_t        state, state_n;
    req_t          pending, pending_n, req_in;
    logic          is_hit, is_hit_n;
    logic [FW-1:0] frame_idx, frame_idx_n, frame_inc;
    logic [HW-1:0] half_cnt, half_cnt_n, half_last;
    logic          phase, phase_n, pol;
    logic [15:0]   sample, sample_n, amp;
    logic          div_wrap, bclk_fall, boundary;
    logic [4:0]    slot;
    logic [3:0]    bit_sel;
`ifdef SHOT_NOISE_EN
    logic [15:0]   lfsr, lfsr_n, lfsr_step;
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif

    assign div_wrap  = (div_cnt == DW'(BCLK_DIV - 1));
    assign bclk_fall = div_wrap && bclk_q;
    assign boundary  = bclk_fall && (bit_cnt == 6'd63);
    assign frame_inc = frame_idx + FW'(1);
    assign half_last = is_hit ? HW'(HIT_HALF - 1) : HW'(FIRE_HALF - 1);
    // Decay step is the top three bits of the frame index, valid because DUR_FRAMES is a power of two
    assign amp       = AMP_INIT >> frame_inc[FW-1 -: 3];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            bclk_q    <= 1'b0;
            bit_cnt   <= '0;
            state     <= IDLE;
            pending   <= REQ_NONE;
            is_hit    <= 1'b0;
            frame_idx <= '0;
            half_cnt  <= '0;
            phase     <= 1'b1;
            sample    <= '0;
`ifdef SHOT_NOISE_EN
            lfsr      <= 16'hACE1;
`endif
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap)
                bclk_q <= ~bclk_q;
            if (bclk_fall)
                bit_cnt <= bit_cnt + 6'd1;
            state     <= state_n;
            pending   <= pending_n;
            is_hit    <= is_hit_n;
            frame_idx <= frame_idx_n;
            half_cnt  <= half_cnt_n;
            phase     <= phase_n;
            sample    <= sample_n;
`ifdef SHOT_NOISE_EN
            lfsr      <= lfsr_n;
`endif
        end
    end

    always_comb begin
        req_in = REQ_NONE;
        if (hit)
            req_in = REQ_HIT;
        else if (fire)
            req_in = REQ_FIRE;
        state_n     = state;
        pending_n   = pending;
        is_hit_n    = is_hit;
        frame_idx_n = frame_idx;
        half_cnt_n  = half_cnt;
        phase_n     = phase;
        sample_n    = sample;
        pol         = phase;
`ifdef SHOT_NOISE_EN
        lfsr_n      = lfsr;
`endif
        if (req_in == REQ_HIT || (req_in == REQ_FIRE && pending != REQ_HIT))
            pending_n = req_in;
        if (boundary) begin
            if (pending != REQ_NONE) begin
                // A request consumed here makes room for one arriving in the same cycle
                state_n     = PLAY;
                pending_n   = req_in;
                is_hit_n    = (pending == REQ_HIT);
                frame_idx_n = '0;
                half_cnt_n  = '0;
                phase_n     = 1'b1;
                pol         = 1'b1;
`ifdef SHOT_NOISE_EN
                if (pending == REQ_FIRE) begin
                    pol    = lfsr[0];
                    lfsr_n = lfsr_step;
                end
`endif
                sample_n    = pol ? AMP_INIT : 16'h0000 - AMP_INIT;
            end else if (state == PLAY) begin
                if (frame_idx == FW'(DUR_FRAMES - 1)) begin
                    state_n  = IDLE;
                    sample_n = '0;
                end else begin
                    frame_idx_n = frame_inc;
                    if (half_cnt == half_last) begin
                        half_cnt_n = '0;
                        phase_n    = ~phase;
                    end else begin
                        half_cnt_n = half_cnt + HW'(1);
                    end
                    pol = phase_n;
`ifdef SHOT_NOISE_EN
                    if (!is_hit) begin
                        pol    = lfsr[0];
                        lfsr_n = lfsr_step;
                    end
`endif
                    sample_n = pol ? amp : 16'h0000 - amp;
                end
            end
        end
    end

    // Slot 0 is the I2S one-bit delay; slots 1..16 carry the sample MSB first
    assign slot        = bit_cnt[4:0];
    assign bit_sel     = 4'(5'd16 - slot);
    assign aud_bclk    = bclk_q;
    assign aud_daclrck = bit_cnt[5];
    assign aud_dacdat  = (slot != 5'd0 && slot <= 5'd16) ? sample[bit_sel] : 1'b0;
    assign busy        = (state == PLAY);
endmodule
